vco_sum_integrator_ctrl: RTL and testbench

- Sequencer for the three-oscillator VCO summing adder, whose output is a 3-bit signed sum of ±1 oscillator contributions.
- Gates the oscillators, waits a settle time, then integrates the adder's sum over a programmable window.
- Returns a signed accumulated result and a binary spin decision through a start/done/ack handshake.
- Sits between the adder and the upstream update scheduler.

---
 rtl/vco_sum_integrator_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_vco_sum_integrator_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vco_sum_integrator_ctrl.sv
// vco_sum_integrator_ctrl
// Sequencer for the three-oscillator VCO summing adder. It enables the
// oscillators, lets them settle, integrates the synchronized 3-bit signed
// adder sum over a programmable window, and hands a saturated signed result
// plus a spin decision to the consumer through start/done/ack.
//
// Optional build macro: VCO_CTRL_LFSR_TIEBREAK_EN
//   defined   -> a free-running 16-bit LFSR breaks acc==0 ties for spin_out
//   undefined -> acc==0 leaves spin_out at its previous value
module vco_sum_integrator_ctrl #(
  parameter int ACC_W      = 16,
  parameter int WIN_W      = 12,
  parameter int SETTLE_CYC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  input  logic [WIN_W-1:0] window_len,
  input  logic [2:0]       sum_in,
  output logic             osc_en,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             spin_out,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SETTLE    = 2'd1,
    INTEGRATE = 2'd2,
    DONE      = 2'd3
  } state_e;

  // One counter serves both the settle interval and the integration window.
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int CNT_W = (WIN_W > SET_W) ? WIN_W : SET_W;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [ACC_W-1:0] ACC_MAX     = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN     = {1'b1, {(ACC_W-1){1'b0}}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic               spin_q, spin_d;
  logic [7:0]         err_q, err_d;
  logic [2:0]         sync1_q, sync1_d;
  logic [2:0]         sync2_q, sync2_d;

  logic               samp_legal;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   win_last;
  logic               tie_bit;

`ifdef VCO_CTRL_LFSR_TIEBREAK_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16/14/13/11, advancing every cycle.
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, seeded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign tie_bit = lfsr_q[0];
`else
  assign tie_bit = spin_q;
`endif

  // Legal adder codes are the odd ones (+3, +1, -1, -3); even codes add 0.
  assign samp_legal = sync2_q[0];

  // Saturating add: one guard bit detects overflow, which clamps instead of wrapping.
  always_comb begin
    sum_wide = {acc_q[ACC_W-1], acc_q}
             + (samp_legal ? {{(ACC_W-2){sync2_q[2]}}, sync2_q} : {(ACC_W+1){1'b0}});
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) acc_sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else                                      acc_sum = sum_wide[ACC_W-1:0];
  end

  assign win_last = CNT_W'(win_q) - CNT_W'(1);

  // Next-state and datapath updates for the measurement sequence.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned, which would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    spin_d    = spin_q;
    err_d     = err_q;
    sync1_d   = sum_in;
    sync2_d   = sync1_q;

    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = SETTLE;
          cnt_d   = '0;
          win_d   = window_len;
          acc_d   = '0;
          err_d   = '0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (win_q == '0) begin
            state_d   = DONE;
            acc_out_d = '0;
            spin_d    = tie_bit;
          end else begin
            state_d = INTEGRATE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      INTEGRATE: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_sum;
          if (!samp_legal && err_q != 8'hFF) err_d = err_q + 8'd1;
          if (cnt_q == win_last) begin
            state_d   = DONE;
            acc_out_d = acc_sum;
            if (acc_sum == '0) spin_d = tie_bit;
            else               spin_d = ~acc_sum[ACC_W-1];
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        if (ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, synchronizer and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      acc_q     <= '0;
      acc_out_q <= '0;
      spin_q    <= 1'b0;
      err_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values; sync2_q must see the old sync1_q.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      spin_q    <= spin_d;
      err_q     <= err_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
    end
  end

  assign osc_en   = (state_q == SETTLE) || (state_q == INTEGRATE);
  assign busy     = osc_en;
  assign done     = (state_q == DONE);
  assign acc_out  = acc_out_q;
  assign spin_out = spin_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_vco_sum_integrator_ctrl.sv
// Testbench for vco_sum_integrator_ctrl: a 16-bit and an 8-bit accumulator
// instance share stimulus; a measurement-level model is compared on every
// falling edge, and directed literals pin results and latencies.
module tb_vco_sum_integrator_ctrl;

  localparam int S = 8;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, ack;
  logic [11:0] window_len;
  logic [2:0]  sum_in;

  logic        osc16, busy16, done16, spin16;
  logic [15:0] acc16;
  logic [7:0]  err16;
  logic        osc8, busy8, done8, spin8;
  logic [7:0]  acc8;
  logic [7:0]  err8;

  int checks   = 0;
  int failures = 0;

  vco_sum_integrator_ctrl dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ack(ack),
    .window_len(window_len), .sum_in(sum_in),
    .osc_en(osc16), .busy(busy16), .done(done16),
    .acc_out(acc16), .spin_out(spin16), .err_cnt(err16)
  );

  vco_sum_integrator_ctrl #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .ack(ack),
    .window_len(window_len), .sum_in(sum_in),
    .osc_en(osc8), .busy(busy8), .done(done8),
    .acc_out(acc8), .spin_out(spin8), .err_cnt(err8)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clamp(input int v, input int w);
    int hi, lo;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Measurement-level model: edges since the accepted start decide when samples
  // count and when the result appears; samples arrive two edges late.
  bit              m_active = 0, m_done = 0;
  int              m_n = 0, m_w = 0, m_err = 0;
  int              m_acc16 = 0, m_acc8 = 0, m_out16 = 0, m_out8 = 0;
  bit              m_spin16 = 0, m_spin8 = 0;
  logic [2:0]      s_d1 = '0, s_d2 = '0;
  logic signed [2:0] smp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_done = 0; m_n = 0; m_w = 0; m_err = 0;
      m_acc16 = 0; m_acc8 = 0; m_out16 = 0; m_out8 = 0;
      m_spin16 = 0; m_spin8 = 0; s_d1 = '0; s_d2 = '0;
    end else begin
      smp  = s_d2;
      s_d2 = s_d1;
      s_d1 = sum_in;
      if (m_active) begin
        if (abort) m_active = 0;
        else begin
          m_n++;
          if (m_n > S) begin
            if (smp[0]) begin
              m_acc16 = clamp(m_acc16 + int'(smp), 16);
              m_acc8  = clamp(m_acc8 + int'(smp), 8);
            end else if (m_err < 255) m_err++;
          end
          if (m_n == S + m_w) begin
            m_active = 0;
            m_done   = 1;
            m_out16  = m_acc16;
            m_out8   = m_acc8;
            if (m_acc16 > 0) m_spin16 = 1; else if (m_acc16 < 0) m_spin16 = 0;
            if (m_acc8 > 0)  m_spin8 = 1;  else if (m_acc8 < 0)  m_spin8 = 0;
          end
        end
      end else if (m_done) begin
        if (ack) m_done = 0;
      end else if (start && !abort) begin
        m_active = 1; m_n = 0; m_w = int'(window_len);
        m_acc16 = 0; m_acc8 = 0; m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("osc_en16", osc16, m_active);
    check("busy16", busy16, m_active);
    check("done16", done16, m_done);
    check("acc_out16", $signed(acc16), m_out16);
    check("spin16", spin16, m_spin16);
    check("err16", err16, m_err);
    check("busy8", busy8, m_active);
    check("done8", done8, m_done);
    check("acc_out8", $signed(acc8), m_out8);
    check("spin8", spin8, m_spin8);
    check("err8", err8, m_err);
  end

  // Start a measurement and return the number of edges from the start edge to done.
  task automatic measure(input logic [11:0] w, input logic [2:0] s, input bit alt,
                         output int lat);
    @(negedge clk);
    sum_in = s; window_len = w; start = 1'b1;
    @(posedge clk); #1;
    check("busy_after_start", busy16, 1);
    @(negedge clk);
    start = 1'b0; window_len = ~w;
    for (lat = 1; lat <= 5000; lat++) begin
      @(posedge clk); #1;
      if (done16) break;
      if (alt) sum_in = (sum_in == 3'b000) ? 3'b001 : 3'b000;
    end
  endtask

  // Acknowledge the result with start also high; start must be ignored.
  task automatic accept();
    @(negedge clk);
    ack = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("done_falls_on_ack", done16, 0);
    check("start_ignored_in_done", busy16, 0);
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ack = 1'b0;
    window_len = '0; sum_in = '0;
    #12;
    check("rst_osc_en", osc16, 0);
    check("rst_busy", busy16, 0);
    check("rst_done", done16, 0);
    check("rst_acc", $signed(acc16), 0);
    check("rst_spin", spin16, 0);
    check("rst_err", err16, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // +3 over 10 samples
    measure(12'd10, 3'b011, 0, lat);
    check("lat_w10", lat, 18);
    check("acc_p3_w10", $signed(acc16), 30);
    check("spin_p3_w10", spin16, 1);
    check("err_p3_w10", err16, 0);
    repeat (2) @(negedge clk);
    check("done_held", done16, 1);
    accept();

    // +3 over 50 samples: 8-bit instance saturates at +127
    measure(12'd50, 3'b011, 0, lat);
    check("lat_w50", lat, 58);
    check("acc16_p3_w50", $signed(acc16), 150);
    check("acc8_sat_pos", $signed(acc8), 127);
    accept();

    // alternating illegal 0 and +1
    measure(12'd10, 3'b001, 1, lat);
    check("acc_alt", $signed(acc16), 5);
    check("err_alt", err16, 5);
    accept();

    // -3 over 4 samples
    measure(12'd4, 3'b101, 0, lat);
    check("lat_w4", lat, 12);
    check("acc_m3_w4", acc16, 16'hFFF4);
    check("spin_m3_w4", spin16, 0);
    accept();

    // zero window: result 0, spin held at 0
    measure(12'd0, 3'b101, 0, lat);
    check("lat_w0", lat, 8);
    check("acc_w0", $signed(acc16), 0);
    check("spin_w0_held", spin16, 0);
    accept();

    // -3 over 50 samples: 8-bit instance saturates at -128
    measure(12'd50, 3'b101, 0, lat);
    check("acc16_m3_w50", $signed(acc16), -150);
    check("acc8_sat_neg", $signed(acc8), -128);
    check("spin8_neg", spin8, 0);
    accept();

    // abort 3 cycles into INTEGRATE, with a start pulse while busy
    @(negedge clk);
    sum_in = 3'b011; window_len = 12'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= S + 3; k++) begin
      @(posedge clk); #1;
      start = (k == 3);
    end
    start = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_osc_en", osc16, 0);
    check("abort_busy", busy16, 0);
    check("abort_done", done16, 0);
    check("abort_acc_kept", $signed(acc16), -150);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done16 || busy16) seen = 1;
    end
    check("abort_no_done", seen, 0);

    // abort and start together in IDLE: no start
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    check("abort_beats_start", busy16, 0);
    @(negedge clk);
    abort = 1'b0; start = 1'b0;

    // reset mid-INTEGRATE
    @(negedge clk);
    sum_in = 3'b011; window_len = 12'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= S + 2; k++) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_osc_en", osc16, 0);
    check("mid_rst_busy", busy16, 0);
    check("mid_rst_acc", $signed(acc16), 0);
    check("mid_rst_acc8", $signed(acc8), 0);
    check("mid_rst_spin", spin16, 0);
    check("mid_rst_err", err16, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // normal operation after reset: +1 over 6 samples
    measure(12'd6, 3'b001, 0, lat);
    check("lat_after_rst", lat, 14);
    check("acc_after_rst", $signed(acc16), 6);
    check("spin_after_rst", spin16, 1);
    accept();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
